sync_fifo_flags: RTL and testbench
==================================

Name: sync_fifo_flags

Overview:
- Parametrised synchronous FIFO; next generation of the UART TX/RX buffer.
- Adds to the basic FIFO: arbitrary (non-power-of-2) depth, fill-level count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, and a read-data valid strobe.
- Sits between the UART core and the host-side register interface; one clock domain.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 8, number of storage entries (>=2, need not be a power of 2)
AF_LEVEL, DEPTH-2, o_almost_full asserted when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, o_almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)
CW, $clog2(DEPTH+1), width of the count output (derived; not overridden)

Ports:
i_clk  in  1  clock, all logic on rising edge
i_rst  in  1  synchronous active-high reset
i_wr_data  in  WIDTH  write data
i_wr  in  1  write request
i_rd  in  1  read request
i_clr_err  in  1  clears o_overflow/o_underflow
o_rd_data  out  WIDTH  read data
o_rd_valid  out  1  o_rd_data holds a newly popped word
o_full  out  1  count == DEPTH
o_empty  out  1  count == 0
o_almost_full  out  1  count >= AF_LEVEL
o_almost_empty  out  1  count <= AE_LEVEL
o_count  out  CW  current fill level, 0..DEPTH
o_overflow  out  1  sticky: write attempted while full
o_underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset (i_rst high at an edge): wr_ptr=0, rd_ptr=0, count=0, o_rd_data=0, o_rd_valid=0, o_overflow=0, o_underflow=0. Flags follow: o_empty=1, o_full=0, o_almost_empty=1, o_almost_full=(AF_LEVEL==0 ? 1 : 0). Memory contents are not reset. Reset mid-operation discards all data; it overrides i_wr, i_rd and i_clr_err on the same edge.
- Accepted write: wr_acc = i_wr & ~full_eff, where full_eff = o_full & ~rd_acc. This means a write to a full FIFO is accepted only when a read is accepted on the same edge. mem[wr_ptr] <= i_wr_data.
- Accepted read: rd_acc = i_rd & ~o_empty. Reads never use same-cycle write data, so a read on an empty FIFO is always rejected.
- Pointers wrap explicitly: ptr <= (ptr == DEPTH-1) ? 0 : ptr+1. No power-of-2 masking.
- Count: +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither.
- All status flags are decoded combinationally from the registered count. They are valid the cycle after the causing edge.
- Rejected write (i_wr & ~wr_acc): data dropped, o_overflow <= 1.
- Rejected read (i_rd & o_empty): o_underflow <= 1; o_rd_data holds its value; o_rd_valid <= 0.
- Sticky flags: i_clr_err clears both. If a new error and i_clr_err occur on the same edge, the error wins (flag = 1).
- Simultaneous read and write:
  - when empty: write accepted, read rejected (underflow set), count 0->1.
  - when full: both accepted, count stays DEPTH, no overflow.
  - otherwise: both accepted, count unchanged.
- Standard read timing: on the rd_acc edge, o_rd_data <= mem[rd_ptr] and o_rd_valid <= 1. With no rd_acc, o_rd_valid <= 0. Latency is one cycle from i_rd to data.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN (first-word fall-through).
- Defined:
  - o_rd_data = mem[rd_ptr] combinationally whenever ~o_empty; forced to 0 when empty.
  - o_rd_valid = ~o_empty (combinational).
  - i_rd acknowledges/pops the presented word; the next word appears the cycle after.
  - Count, flags and error rules are unchanged.
- Not defined: the standard registered read timing above applies.

Test Plan:
- DEPTH=8. Reset, then write 10..19 on consecutive cycles -> first 8 accepted. o_count steps 1..8. o_almost_full rises at count 6. o_full=1 after the 8th write. o_overflow=1 after the 9th attempt. Words 18,19 are lost.
- Read 12 times from full -> o_rd_data = 10..17 with o_rd_valid pulses (FWFT: 10 shown before the first i_rd). o_almost_empty rises at count 2. o_empty=1 after the 8th read. o_underflow=1 after the 9th.
- Pulse i_clr_err -> both sticky flags 0. Assert i_clr_err together with a read on empty -> o_underflow stays 1.
- Empty FIFO, i_wr=i_rd=1 with data 0x55 -> count=1, o_underflow=1, next read returns 0x55.
- Fill to 8, then 20 cycles of simultaneous wr/rd with data 30..49 -> count stays 8, no overflow. Reads return 10..17 then 30..41 in order; this covers pointer wrap multiple times.
- DEPTH=5 rebuild: 13 writes/reads interleaved at count 3 -> data order preserved across wrap at index 4->0. Mid-stream i_rst -> o_count=0, o_empty=1 next cycle, and the following read sets o_underflow.

Source files
------------

// File: rtl/sync_fifo_flags.sv
// Synchronous FIFO with arbitrary depth, fill count, almost-full/empty flags,
// sticky overflow/underflow and read-valid strobe. Define SYNC_FIFO_FWFT_EN for first-word fall-through.
module sync_fifo_flags #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_wr,
  input  logic             i_rd,
  input  logic             i_clr_err,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_rd_valid,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_almost_full,
  output logic             o_almost_empty,
  output logic [CW-1:0]    o_count,
  output logic             o_overflow,
  output logic             o_underflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             rd_acc;
  logic             wr_acc;
  logic             full_eff;

  // Request/accept semantics: i_wr and i_rd are single-cycle requests with no
  // back-pressure. A read is accepted whenever the FIFO holds data; a write is
  // accepted unless full, except that a full FIFO accepts a write paired with
  // an accepted read. Rejected requests are dropped and raise a sticky error.
  assign rd_acc   = i_rd & ~o_empty;
  assign full_eff = o_full & ~rd_acc;
  assign wr_acc   = i_wr & ~full_eff;

  assign o_count        = count;
  assign o_full         = (count == CW'(DEPTH));
  assign o_empty        = (count == '0);
  assign o_almost_full  = (count >= CW'(AF_LEVEL));
  assign o_almost_empty = (count <= CW'(AE_LEVEL));

  always_ff @(posedge i_clk) begin
    if (!i_rst && wr_acc) mem[wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A new error on the same edge as a clear wins.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      o_overflow  <= (i_wr & ~wr_acc) | (o_overflow  & ~i_clr_err);
      o_underflow <= (i_rd & o_empty) | (o_underflow & ~i_clr_err);
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign o_rd_data  = o_empty ? '0 : mem[rd_ptr];
  assign o_rd_valid = ~o_empty;
`else
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_valid_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
      if (rd_acc) rd_data_q <= mem[rd_ptr];
    end
  end

  assign o_rd_data  = rd_data_q;
  assign o_rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags: a DEPTH=8 and a DEPTH=5 instance checked
// against a behavioural queue model with a read-data scoreboard.
module tb_sync_fifo_flags;

  logic       clk;
  logic       rst8, wr8, rd8, clr8;
  logic       rst5, wr5, rd5, clr5;
  logic [7:0] wd8, wd5;
  logic [7:0] rdat8, rdat5;
  logic       val8, full8, empty8, af8, ae8, ovf8, unf8;
  logic       val5, full5, empty5, af5, ae5, ovf5, unf5;
  logic [3:0] cnt8;
  logic [2:0] cnt5;

  sync_fifo_flags #(.WIDTH(8), .DEPTH(8)) u8 (
    .i_clk(clk), .i_rst(rst8), .i_wr_data(wd8), .i_wr(wr8), .i_rd(rd8),
    .i_clr_err(clr8), .o_rd_data(rdat8), .o_rd_valid(val8), .o_full(full8),
    .o_empty(empty8), .o_almost_full(af8), .o_almost_empty(ae8),
    .o_count(cnt8), .o_overflow(ovf8), .o_underflow(unf8)
  );

  sync_fifo_flags #(.WIDTH(8), .DEPTH(5)) u5 (
    .i_clk(clk), .i_rst(rst5), .i_wr_data(wd5), .i_wr(wr5), .i_rd(rd5),
    .i_clr_err(clr5), .o_rd_data(rdat5), .o_rd_valid(val5), .o_full(full5),
    .o_empty(empty5), .o_almost_full(af5), .o_almost_empty(ae5),
    .o_count(cnt5), .o_overflow(ovf5), .o_underflow(unf5)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model and scoreboard state
  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  bit         cur5;
  bit         e_ovf, e_unf, e_valid;
  logic [7:0] e_rd;
  int         n_cmp, n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    int depth  = cur5 ? 5 : 8;
    int af_lvl = cur5 ? 3 : 6;
    int sz     = mq.size();
    if (cur5) begin
      chk({tag, ":count"}, {29'b0, cnt5}, sz);
      chk({tag, ":empty"}, {31'b0, empty5}, {31'b0, sz == 0});
      chk({tag, ":full"},  {31'b0, full5},  {31'b0, sz == depth});
      chk({tag, ":af"},    {31'b0, af5},    {31'b0, sz >= af_lvl});
      chk({tag, ":ae"},    {31'b0, ae5},    {31'b0, sz <= 2});
      chk({tag, ":ovf"},   {31'b0, ovf5},   {31'b0, e_ovf});
      chk({tag, ":unf"},   {31'b0, unf5},   {31'b0, e_unf});
      chk({tag, ":valid"}, {31'b0, val5},   {31'b0, e_valid});
      if (val5 === 1'b1 && exp_q.size() > 0) e_rd = exp_q.pop_front();
      chk({tag, ":rdata"}, {24'b0, rdat5},  {24'b0, e_rd});
    end else begin
      chk({tag, ":count"}, {28'b0, cnt8}, sz);
      chk({tag, ":empty"}, {31'b0, empty8}, {31'b0, sz == 0});
      chk({tag, ":full"},  {31'b0, full8},  {31'b0, sz == depth});
      chk({tag, ":af"},    {31'b0, af8},    {31'b0, sz >= af_lvl});
      chk({tag, ":ae"},    {31'b0, ae8},    {31'b0, sz <= 2});
      chk({tag, ":ovf"},   {31'b0, ovf8},   {31'b0, e_ovf});
      chk({tag, ":unf"},   {31'b0, unf8},   {31'b0, e_unf});
      chk({tag, ":valid"}, {31'b0, val8},   {31'b0, e_valid});
      if (val8 === 1'b1 && exp_q.size() > 0) e_rd = exp_q.pop_front();
      chk({tag, ":rdata"}, {24'b0, rdat8},  {24'b0, e_rd});
    end
  endtask

  // driver: one clock of stimulus on the selected instance, model update, check
  task automatic step(input string tag, input logic w, input logic r,
                      input logic [7:0] d, input logic c);
    int  depth = cur5 ? 5 : 8;
    bit  racc, wacc;
    if (cur5) begin wr5 = w; rd5 = r; wd5 = d; clr5 = c; end
    else      begin wr8 = w; rd8 = r; wd8 = d; clr8 = c; end
    racc = r && (mq.size() > 0);
    wacc = w && ((mq.size() < depth) || racc);
    if (racc) exp_q.push_back(mq.pop_front());
    if (wacc) mq.push_back(d);
    e_ovf   = (w && !wacc) || (e_ovf && !c);
    e_unf   = (r && !racc) || (e_unf && !c);
    e_valid = racc;
    tick();
    check_all(tag);
    wr8 = 0; rd8 = 0; clr8 = 0; wr5 = 0; rd5 = 0; clr5 = 0;
  endtask

  // reset with a write/read/clear request on the same edge to show it is overridden
  task automatic do_reset(input string tag);
    if (cur5) begin rst5 = 1; wr5 = 1; rd5 = 1; clr5 = 1; end
    else      begin rst8 = 1; wr8 = 1; rd8 = 1; clr8 = 1; end
    tick();
    rst8 = 0; rst5 = 0;
    wr8 = 0; rd8 = 0; clr8 = 0; wr5 = 0; rd5 = 0; clr5 = 0;
    mq.delete();
    exp_q.delete();
    e_ovf = 0; e_unf = 0; e_valid = 0; e_rd = 8'h00;
    check_all(tag);
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; cur5 = 0;
    rst8 = 1; rst5 = 1;
    wr8 = 0; rd8 = 0; clr8 = 0; wd8 = 0;
    wr5 = 0; rd5 = 0; clr5 = 0; wd5 = 0;
    e_rd = 8'h00;
    tick();

    // DEPTH=8: fill past full, drain past empty
    do_reset("rst8");
    for (int i = 10; i < 20; i++) step("fill", 1, 0, 8'(i), 0);
    for (int i = 0; i < 12; i++) step("drain", 0, 1, 8'h00, 0);
    step("clr", 0, 0, 8'h00, 1);
    step("clr_vs_unf", 0, 1, 8'h00, 1);
    step("clr2", 0, 0, 8'h00, 1);

    // simultaneous read/write on empty: write wins, read underflows
    step("wr_rd_empty", 1, 1, 8'h55, 0);
    step("rd_55", 0, 1, 8'h00, 1);

    // full with continuous simultaneous traffic, wraps pointers repeatedly
    for (int i = 10; i < 18; i++) step("refill", 1, 0, 8'(i), 0);
    for (int i = 30; i < 50; i++) step("wr_rd_full", 1, 1, 8'(i), 0);
    for (int i = 0; i < 8; i++) step("drain2", 0, 1, 8'h00, 0);
    for (int i = 0; i < 6; i++)
      step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

    // DEPTH=5: interleave around count 3, wrap at index 4->0
    cur5 = 1;
    do_reset("rst5");
    for (int i = 0; i < 3; i++) step("pre5", 1, 0, 8'(8'h60 + i), 0);
    for (int i = 0; i < 13; i++) begin
      step("il_wr", 1, 0, 8'(8'h70 + i), 0);
      step("il_rd", 0, 1, 8'h00, 0);
    end
    step("mid_wr", 1, 0, 8'hA5, 0);
    do_reset("mid_rst");
    step("post_rst_rd", 0, 1, 8'h00, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
